// File: rtl/eth_rx_frame_fifo_if.sv
// rtl/eth_rx_frame_fifo_if.sv - receive-side and consumer-side signal bundle for the frame FIFO
interface eth_rx_frame_fifo_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_err;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        buffer_full;
    logic        frame_drop;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    // Producer/consumer environment side
    modport master (
        output in_data, in_valid, in_last, in_err, out_ready,
        input  out_data, out_valid, out_last, buffer_full, frame_drop, frame_count, drop_count
    );

    // FIFO side
    modport slave (
        input  in_data, in_valid, in_last, in_err, out_ready,
        output out_data, out_valid, out_last, buffer_full, frame_drop, frame_count, drop_count
    );
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// rtl/eth_rx_frame_fifo.sv - store-and-forward receive frame buffer with commit/rollback
module eth_rx_frame_fifo #(
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    eth_rx_frame_fifo_if.slave  bus
);
    localparam int              PW       = ADDR_W + 1;
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [PW-1:0]   PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [PW-1:0]   FULL_GAP = {1'b1, {ADDR_W{1'b0}}};

    logic [8:0]    mem [DEPTH];
    logic [8:0]    mem_rdata_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
    logic          overflow_q, overflow_d;
    logic          full_q, full_d;
    logic          drop_q, drop_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic          mem_valid_q, mem_valid_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    logic          mem_we;
    logic          fetch;
    logic          out_load;

    // Write side: store bytes while space remains, then commit or roll back on the last byte
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        commit_ptr_d  = commit_ptr_q;
        overflow_d    = overflow_q;
        drop_d        = 1'b0;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        mem_we        = 1'b0;
        if (bus.in_valid) begin
            if (!full_q) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                overflow_d = 1'b1;
            end
            if (bus.in_last) begin
                overflow_d = 1'b0;
                // A last byte that itself hits a full buffer is lost, so the frame is bad too
                if (bus.in_err || overflow_q || full_q) begin
                    wr_ptr_d = commit_ptr_q;
                    drop_d   = 1'b1;
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                end else begin
                    commit_ptr_d  = wr_ptr_q + PTR_ONE;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
        end
    end

    // Read side: fetch committed bytes into the memory read register, then into the output register
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        fetch_ptr_d = fetch_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_load    = !out_valid_q || bus.out_ready;
        fetch       = (fetch_ptr_q != commit_ptr_q) && (!mem_valid_q || out_load);
        if (out_valid_q && bus.out_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (fetch) begin
            fetch_ptr_d = fetch_ptr_q + PTR_ONE;
        end
        if (out_load) begin
            out_valid_d = mem_valid_q;
            if (mem_valid_q) begin
                out_data_d = mem_rdata_q[7:0];
                out_last_d = mem_rdata_q[8];
            end
        end
        if (fetch) begin
            mem_valid_d = 1'b1;
        end else if (out_load) begin
            mem_valid_d = 1'b0;
        end else begin
            mem_valid_d = mem_valid_q;
        end
        // Occupancy counts bytes until the consumer takes them, including those in the pipeline
        full_d = (wr_ptr_d - rd_ptr_d) == FULL_GAP;
    end

    // Frame storage with synchronous read; contents are never cleared
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {bus.in_last, bus.in_data};
        end
        if (fetch) begin
            mem_rdata_q <= mem[fetch_ptr_q[ADDR_W-1:0]];
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            fetch_ptr_q   <= '0;
            overflow_q    <= 1'b0;
            full_q        <= 1'b0;
            drop_q        <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            mem_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fetch_ptr_q   <= fetch_ptr_d;
            overflow_q    <= overflow_d;
            full_q        <= full_d;
            drop_q        <= drop_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            mem_valid_q   <= mem_valid_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.buffer_full = full_q;
    assign bus.frame_drop  = drop_q;
    assign bus.frame_count = frame_count_q;
    assign bus.drop_count  = drop_count_q;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb/tb_eth_rx_frame_fifo.sv - self-checking bench for the receive frame FIFO
module tb_eth_rx_frame_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_err = 1'b0;
    logic       out_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_big[$];
    logic [8:0] exp_small[$];

    always #5 clk = ~clk;

    eth_rx_frame_fifo_if big_if();
    eth_rx_frame_fifo_if small_if();

    assign big_if.in_data    = in_data;
    assign big_if.in_valid   = in_valid;
    assign big_if.in_last    = in_last;
    assign big_if.in_err     = in_err;
    assign big_if.out_ready  = out_ready;
    assign small_if.in_data   = in_data;
    assign small_if.in_valid  = in_valid;
    assign small_if.in_last   = in_last;
    assign small_if.in_err    = in_err;
    assign small_if.out_ready = out_ready;

    eth_rx_frame_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (big_if.slave)
    );

    eth_rx_frame_fifo #(.ADDR_W(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (small_if.slave)
    );

    typedef struct {
        int          len;
        logic        err;
        logic [7:0]  base;
        logic        exp_drop;
        logic [15:0] exp_fc;
        logic [15:0] exp_dc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic err);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_err   = err;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_err   = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input logic err,
                              input logic push_big, input logic push_small);
        logic [7:0] b;
        logic       l;
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            l = (i == len - 1);
            if (push_big)   exp_big.push_back({l, b});
            if (push_small) exp_small.push_back({l, b});
        end
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            send_byte(b, i == len - 1, err && (i == len - 1));
        end
    endtask

    // Reset for one cycle while presenting a would-be committing byte that must be ignored
    task automatic do_reset();
        rst      = 1'b1;
        in_data  = 8'h5F;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_err   = 1'b0;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_big.delete();
        exp_small.delete();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"},   32'(big_if.out_valid),   0);
        chk({tag, "_out_data"},    32'(big_if.out_data),    0);
        chk({tag, "_out_last"},    32'(big_if.out_last),    0);
        chk({tag, "_buffer_full"}, 32'(big_if.buffer_full), 0);
        chk({tag, "_frame_drop"},  32'(big_if.frame_drop),  0);
        chk({tag, "_frame_count"}, 32'(big_if.frame_count), 0);
        chk({tag, "_drop_count"},  32'(big_if.drop_count),  0);
        chk({tag, "_small_valid"}, 32'(small_if.out_valid), 0);
        chk({tag, "_small_fc"},    32'(small_if.frame_count), 0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_big.size() != 0 || exp_small.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_big.size() + exp_small.size()), 0);
        repeat (3) tick();
    endtask

    // Scoreboard for the default-depth instance: order, content, and stall hold
    initial begin
        logic [8:0] e;
        logic [8:0] held;
        logic       stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) chk("big_hold", {23'd0, big_if.out_valid, big_if.out_last, big_if.out_data}, {23'd0, 1'b1, held});
                stall = big_if.out_valid && !out_ready;
                held  = {big_if.out_last, big_if.out_data};
                if (big_if.out_valid && out_ready) begin
                    if (exp_big.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL big_extra: got %0h required no byte at %0t", held, $time);
                    end else begin
                        e = exp_big.pop_front();
                        chk("big_byte", 32'(held), 32'(e));
                    end
                end
            end
        end
    end

    // Scoreboard for the 16-entry instance
    initial begin
        logic [8:0] e;
        logic [8:0] held;
        logic       stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) chk("small_hold", {23'd0, small_if.out_valid, small_if.out_last, small_if.out_data}, {23'd0, 1'b1, held});
                stall = small_if.out_valid && !out_ready;
                held  = {small_if.out_last, small_if.out_data};
                if (small_if.out_valid && out_ready) begin
                    if (exp_small.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL small_extra: got %0h required no byte at %0t", held, $time);
                    end else begin
                        e = exp_small.pop_front();
                        chk("small_byte", 32'(held), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{len: 3, err: 1'b1, base: 8'hA0, exp_drop: 1'b1, exp_fc: 16'd0, exp_dc: 16'd1};
        vecs[1] = '{len: 1, err: 1'b0, base: 8'h5A, exp_drop: 1'b0, exp_fc: 16'd1, exp_dc: 16'd1};
        vecs[2] = '{len: 6, err: 1'b0, base: 8'h30, exp_drop: 1'b0, exp_fc: 16'd2, exp_dc: 16'd1};
        vecs[3] = '{len: 2, err: 1'b1, base: 8'h70, exp_drop: 1'b1, exp_fc: 16'd2, exp_dc: 16'd2};
        vecs[4] = '{len: 1, err: 1'b1, base: 8'h90, exp_drop: 1'b1, exp_fc: 16'd2, exp_dc: 16'd3};
        vecs[5] = '{len: 4, err: 1'b0, base: 8'hC0, exp_drop: 1'b0, exp_fc: 16'd3, exp_dc: 16'd3};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_reset_state("rst0");

        // Good 4-byte frame: out_valid rises two edges after the last byte, no bubbles
        out_ready = 1'b1;
        send_frame(4, 8'h11, 1'b0, 1'b1, 1'b1);
        chk("lat_e0", 32'(big_if.out_valid), 0);
        tick();
        chk("lat_e1", 32'(big_if.out_valid), 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("stream_valid", 32'(big_if.out_valid), 1);
            chk("stream_valid_small", 32'(small_if.out_valid), 1);
            tick();
        end
        chk("stream_end", 32'(big_if.out_valid), 0);
        chk("good_fc", 32'(big_if.frame_count), 1);
        wait_drain("drain_good");

        // Table of frames with the consumer always ready
        do_reset();
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].len, vecs[v].base, vecs[v].err, !vecs[v].err, !vecs[v].err);
            chk($sformatf("v%0d_drop", v), 32'(big_if.frame_drop), 32'(vecs[v].exp_drop));
            chk($sformatf("v%0d_fc", v), 32'(big_if.frame_count), 32'(vecs[v].exp_fc));
            chk($sformatf("v%0d_dc", v), 32'(big_if.drop_count), 32'(vecs[v].exp_dc));
            chk($sformatf("v%0d_small_dc", v), 32'(small_if.drop_count), 32'(vecs[v].exp_dc));
            tick();
            chk($sformatf("v%0d_drop_end", v), 32'(big_if.frame_drop), 0);
        end
        wait_drain("drain_table");

        // Frames A good, B bad, C good held back, then released
        do_reset();
        out_ready = 1'b0;
        send_frame(5, 8'h01, 1'b0, 1'b1, 1'b1);
        send_frame(4, 8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(2, 8'h81, 1'b0, 1'b1, 1'b1);
        repeat (4) tick();
        chk("abc_stalled_valid", 32'(big_if.out_valid), 1);
        chk("abc_first", 32'({big_if.out_last, big_if.out_data}), 32'h001);
        out_ready = 1'b1;
        wait_drain("drain_abc");
        chk("abc_fc", 32'(big_if.frame_count), 2);
        chk("abc_dc", 32'(big_if.drop_count), 1);

        // Overflow on the 16-entry instance; the deep instance takes the frame whole
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) exp_big.push_back({(i == 19), 8'(i)});
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i), i == 19, 1'b0);
            if (i == 14) chk("ovf_not_full_15", 32'(small_if.buffer_full), 0);
            if (i == 15) chk("ovf_full_16", 32'(small_if.buffer_full), 1);
            if (i == 15) chk("ovf_big_not_full", 32'(big_if.buffer_full), 0);
        end
        chk("ovf_drop_pulse", 32'(small_if.frame_drop), 1);
        chk("ovf_dc", 32'(small_if.drop_count), 1);
        chk("ovf_fc", 32'(small_if.frame_count), 0);
        chk("ovf_full_after", 32'(small_if.buffer_full), 0);
        chk("ovf_big_fc", 32'(big_if.frame_count), 1);
        chk("ovf_big_dc", 32'(big_if.drop_count), 0);
        send_frame(3, 8'hE0, 1'b0, 1'b1, 1'b1);
        chk("ovf_next_fc", 32'(small_if.frame_count), 1);
        chk("ovf_next_dc", 32'(small_if.drop_count), 1);
        repeat (2) tick();
        chk("ovf_next_valid", 32'(small_if.out_valid), 1);
        out_ready = 1'b1;
        wait_drain("drain_ovf");

        // Back-pressure pattern 1,0,0,1 while a frame is delivered
        do_reset();
        out_ready = 1'b1;
        send_frame(4, 8'hB0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk("bp_valid", 32'(big_if.out_valid), 1);
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        chk("bp_held", 32'({big_if.out_valid, big_if.out_data}), 32'h1B1);
        out_ready = 1'b1;
        wait_drain("drain_bp");

        // Reset with a committed frame and a partial frame in flight
        do_reset();
        out_ready = 1'b0;
        send_frame(3, 8'h10, 1'b0, 1'b1, 1'b1);
        send_byte(8'h20, 1'b0, 1'b0);
        send_byte(8'h21, 1'b0, 1'b0);
        repeat (3) tick();
        chk("pre_rst_valid", 32'(big_if.out_valid), 1);
        do_reset();
        check_reset_state("rst1");
        out_ready = 1'b1;
        send_frame(4, 8'h60, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_after_rst");
        chk("after_rst_fc", 32'(big_if.frame_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
